// File: rtl/spi_byte_feeder_if.sv
// Host-write and transmitter-handshake bundle for spi_byte_feeder.
// master = host/transmitter environment, slave = the feeder itself.
interface spi_byte_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              clr_overflow;
  logic              spi_busy;
  logic              spi_data_rdy;
  logic [7:0]        spi_data;
  logic              busy;

  modport master (
    output wr_en, wr_data, clr_overflow, spi_busy,
    input  full, empty, level, overflow, spi_data_rdy, spi_data, busy
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow, spi_busy,
    output full, empty, level, overflow, spi_data_rdy, spi_data, busy
  );
endinterface

// File: rtl/spi_byte_feeder.sv
// Byte FIFO plus dispatcher feeding one byte at a time to the SPI transmitter.
// Optional macro SPI_FEED_GAP_EN adds a GAP_CYCLES idle gap after each byte.
module spi_byte_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
`ifdef SPI_FEED_GAP_EN
  , parameter int GAP_CYCLES = 4
`endif
) (
  input logic              clk,
  input logic              rst,
  spi_byte_feeder_if.slave bus
);

`ifdef SPI_FEED_GAP_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;
  logic [7:0]        gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
`endif

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_q, level_nxt;
  logic              full_q, empty_q, overflow_q;
  logic              push, pop, drop;
  state_t            state;
  logic              rdy_q;
  logic [7:0]        data_q;

  // A pop frees a slot in the same edge, so a write at full still fits.
  assign pop  = (state == IDLE) && !empty_q && !bus.spi_busy;
  assign push = bus.wr_en && (!full_q || pop);
  assign drop = bus.wr_en && !push;

  always_comb begin
    // NOTE: default first so every path assigns level_nxt and no latch is inferred.
    level_nxt = level_q;
    if (push && !pop)
      level_nxt = level_q + (ADDR_W+1)'(1);
    else if (pop && !push)
      level_nxt = level_q - (ADDR_W+1)'(1);
  end

  // NOTE: storage array has no reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.wr_data;
  end

  // NOTE: non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == FULL_LEVEL);
      empty_q <= (level_nxt == '0);
      if (drop)
        overflow_q <= 1'b1;
      else if (bus.clr_overflow)
        overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rdy_q  <= 1'b0;
      data_q <= 8'h00;
`ifdef SPI_FEED_GAP_EN
      gap_cnt <= 8'd0;
`endif
    end else begin
      rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            data_q <= mem[rd_ptr];
            rdy_q  <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE:     state <= WAIT_ACK;
        WAIT_ACK:  if (bus.spi_busy) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!bus.spi_busy) begin
`ifdef SPI_FEED_GAP_EN
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= 8'd0;
              state   <= GAP;
            end
`else
            state <= IDLE;
`endif
          end
        end
`ifdef SPI_FEED_GAP_EN
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1))
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + 8'd1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.spi_data_rdy = rdy_q;
  assign bus.spi_data     = data_q;
  assign bus.busy         = !empty_q || (state != IDLE);

endmodule

// File: doc/spi_byte_feeder.md
Name: spi_byte_feeder

Overview:
Byte queue and dispatcher upstream of the 8-bit serial transmitter (spi). Buffers bytes written by a host (display/command sequencer) in a small FIFO. Presents one byte at a time to the transmitter using its data_rdy/busy handshake, so the host never has to poll the transmitter's busy.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
ADDR_W, 4, log2(DEPTH); pointer width.
GAP_CYCLES, 4, minimum idle clk cycles between transmitter busy falling and the next spi_data_rdy; used only with SPI_FEED_GAP_EN.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-low reset (0 = reset).
wr_en  in  1  host write strobe; one byte per cycle.
wr_data  in  8  host byte.
full  out  1  FIFO holds DEPTH bytes.
empty  out  1  FIFO holds 0 bytes.
level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was attempted while full.
clr_overflow  in  1  clears overflow (synchronous).
spi_busy  in  1  transmitter busy.
spi_data_rdy  out  1  request to transmitter; single-cycle pulse.
spi_data  out  8  byte to transmitter; valid while spi_data_rdy=1 and held until spi_busy is seen high.
busy  out  1  high when FIFO is non-empty or the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, async), all outputs and state forced:
  - pointers=0, level=0, empty=1, full=0, overflow=0
  - spi_data_rdy=0, spi_data=8'h00, FSM=IDLE, busy=0
- FIFO:
  - Circular buffer; wr/rd pointers are ADDR_W bits and wrap DEPTH-1 -> 0.
  - level is a separate counter.
  - Write accepted when wr_en=1 and (full=0, or a pop happens in the same cycle).
  - Write with full=1 and no same-cycle pop is dropped; overflow set to 1 the next cycle.
  - Simultaneous push and pop: level unchanged; both pointers advance.
  - Pop while empty is impossible by construction.
  - full, empty and level are registered and reflect the state after the current edge.
- clr_overflow and overflow-set in the same cycle: set wins.
- Dispatch FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE (plus GAP when the optional feature is enabled).
  - IDLE: if empty=0 and spi_busy=0, pop the head into spi_data and go to ISSUE.
  - ISSUE: spi_data_rdy=1 for exactly this cycle; go to WAIT_ACK.
  - WAIT_ACK: spi_data_rdy=0; spi_data held; stay until spi_busy=1, then WAIT_DONE.
  - WAIT_DONE: stay while spi_busy=1. On spi_busy=0, go to IDLE (or GAP with the feature).
- Latency: a byte written into an empty FIFO with an idle transmitter is popped 2 cycles after its wr_en cycle (write registers at edge 1; IDLE pop at edge 2); spi_data_rdy is high in the following cycle (third cycle counting wr_en's as the first).
- Back-to-back bytes are never overlapped: the next pop happens only after busy has been seen rising and falling.
- spi_data changes only on a pop.
- Reset mid-transfer: FSM returns to IDLE and the FIFO is emptied. The transmitter's own reset handles its state; the feeder does not re-send the lost byte.

Optional Feature:
- Macro SPI_FEED_GAP_EN.
- Defined:
  - Adds state GAP with an 8-bit counter.
  - WAIT_DONE -> GAP on spi_busy=0; GAP counts GAP_CYCLES clk cycles, then goes to IDLE.
  - Guarantees strobe-high time between bytes for display controllers.
  - GAP_CYCLES=0 behaves as not defined.
- Not defined: WAIT_DONE -> IDLE directly; the GAP state and counter are absent.

Test Plan:
- Single byte: write 8'hA5 with spi stub idle -> spi_data=8'hA5 and spi_data_rdy high for exactly one cycle, 3 cycles after wr_en; busy=1 until the stub drops spi_busy, then busy=0.
- Burst ordering: write 8'h01..8'h05 back-to-back with the real spi (CYCLES=1) attached -> dev_dio serialises 01,02,03,04,05 LSB-first in order; no byte issued while spi_busy=1; level peaks at 4.
- Full/overflow: hold spi_busy=1 and write DEPTH+1 bytes -> full=1 after DEPTH writes, level=16, overflow=1, last byte dropped. clr_overflow -> overflow=0.
- Simultaneous push/pop at full: FIFO full and FSM popping in the same cycle as wr_en -> write accepted, level stays 16, overflow stays 0.
- Reset mid-operation: assert rst=0 while in WAIT_DONE with 3 bytes queued -> outputs return to reset values immediately (async); after release, empty=1 and no spi_data_rdy pulse.
- SPI_FEED_GAP_EN with GAP_CYCLES=4: two queued bytes -> exactly 4 cycles between spi_busy falling and the IDLE pop, i.e. spi_data_rdy rises 6 cycles after busy falls (GAP 4, IDLE 1, ISSUE 1); without the macro, 2 cycles.
